serial_bit_tx: RTL

Parallel-to-serial transmitter that writes the single-bit data stream captured by the team's negedge D flip-flop receivers. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a true/complement pair and a frame qualifier. A hold/override input freezes transmission and drives a fixed level, giving benches and system logic a synthesizable equivalent of force/release on the line.

---
 rtl/serial_bit_tx_pkg.sv | 15 +
 rtl/serial_bit_tx_shreg.sv | 28 ++
 rtl/serial_bit_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_bit_tx_pkg.sv
// Shared types and helpers for the serial bit transmitter.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_bit_tx_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } tx_state_e;

  // Counter must hold WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_tx_shreg.sv
// Loadable, enable-gated MSB-first shift register with async active-low reset.
// Presents its MSB as the next bit to go out; zeros shift in from the bottom.
module serial_bit_tx_shreg #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (shift_en) begin
      q_q <= q_q << 1;
    end
  end

  assign msb = q_q[WIDTH-1];

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: MSB-first, one bit per clock, with
// true/complement outputs, frame qualifier, done pulse and hold override.
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold_en,
  input  logic             hold_val,
  output logic             sdo,
  output logic             sdo_n,
  output logic             frame,
  output logic             done
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sdo_q, sdo_n_q, sdo_d;
  logic            frame_q, frame_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            sh_load, sh_en, sh_next;
  logic            accept;

  // Registered readiness, gated by hold so a hold blocks accepts in the same cycle.
  assign load_ready = ready_q & ~hold_en;
  assign accept     = load_valid & load_ready;

  // Holds the bits after the MSB; the MSB goes straight to sdo on load.
  serial_bit_tx_shreg #(
    .WIDTH(WIDTH - 1)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (sh_load),
    .shift_en(sh_en),
    .d       (data_in[WIDTH-2:0]),
    .msb     (sh_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    sh_load = 1'b0;
    sh_en   = 1'b0;

    if (hold_en) begin
      // Everything frozen; the release edge simply resumes the normal sequence.
      sdo_d   = hold_val;
      frame_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sdo_d   = IDLE_LEVEL;
          frame_d = 1'b0;
          if (accept) begin
            state_d = StShift;
            cnt_d   = LastCnt;
            sdo_d   = data_in[WIDTH-1];
            frame_d = 1'b1;
            sh_load = 1'b1;
          end
        end
        StShift: begin
          frame_d = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            sdo_d = sh_next;
            sh_en = 1'b1;
          end else begin
            done_d = 1'b1;
            if (accept) begin
              cnt_d   = LastCnt;
              sdo_d   = data_in[WIDTH-1];
              sh_load = 1'b1;
            end else begin
              state_d = StIdle;
              sdo_d   = IDLE_LEVEL;
              frame_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Ready in idle and during the LSB cycle, allowing gapless back-to-back words.
    ready_d = (state_d == StIdle) || (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sdo_q   <= IDLE_LEVEL;
      sdo_n_q <= ~IDLE_LEVEL;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      sdo_n_q <= ~sdo_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign sdo   = sdo_q;
  assign sdo_n = sdo_n_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule
